// File: rtl/c2h_credit_sched_pkg.sv
// ---------------------------------------------------------------------------
// c2h_sched_pkg
// Shared definitions for the C2H credit scheduler slice:
//   - default table depth / credit width / queue-id width
//   - scheduler FSM state type
//   - saturating credit-add helper
// No ports; imported by the interface, the picker and the top.
// ---------------------------------------------------------------------------
package c2h_sched_pkg;

    localparam int DEF_MAX_Q = 16;
    localparam int DEF_CRD_W = 16;
    localparam int DEF_QID_W = 11;

    typedef enum logic {
        IDLE,
        OFFER
    } sched_state_t;

    // Adds two credit values and clips at max_val. The MSB of the result is
    // set when clipping happened, so the caller can raise the overflow flag.
    // Operands are widened to 32 bits so one helper serves any CRD_W <= 31.
    function automatic logic [32:0] crd_sat_add(input logic [31:0] cur,
                                                input logic [31:0] add,
                                                input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, cur} + {1'b0, add};
        if (sum > {1'b0, max_val}) begin
            return {1'b1, max_val};
        end
        return sum;
    endfunction

endpackage

// File: rtl/c2h_credit_sched_if.sv
// ---------------------------------------------------------------------------
// c2h_credit_sched_if
// Bundles the descriptor-status input channel and the packet-grant output
// channel of c2h_credit_sched.
//   tm_dsc_sts_*  : descriptor status from QDMA (master drives, slave accepts)
//   pkt_req_*     : grant offer towards traffic_gen (slave offers, master
//                   accepts with pkt_req_ready)
// Modports: slave = scheduler side, master = QDMA/traffic_gen side.
// ---------------------------------------------------------------------------
interface c2h_credit_sched_if
    import c2h_sched_pkg::*;
#(
    parameter int QID_W = DEF_QID_W
) ();

    logic             tm_dsc_sts_vld;
    logic [QID_W-1:0] tm_dsc_sts_qid;
    logic [15:0]      tm_dsc_sts_avl;
    logic             tm_dsc_sts_qen;
    logic             tm_dsc_sts_dir;
    logic             tm_dsc_sts_mm;
    logic             tm_dsc_sts_qinv;
    logic             tm_dsc_sts_error;
    logic             tm_dsc_sts_rdy;

    logic             pkt_req_valid;
    logic [QID_W-1:0] pkt_req_qid;
    logic             pkt_req_ready;

    modport slave (
        input  tm_dsc_sts_vld, tm_dsc_sts_qid, tm_dsc_sts_avl,
        input  tm_dsc_sts_qen, tm_dsc_sts_dir, tm_dsc_sts_mm,
        input  tm_dsc_sts_qinv, tm_dsc_sts_error,
        output tm_dsc_sts_rdy,
        output pkt_req_valid, pkt_req_qid,
        input  pkt_req_ready
    );

    modport master (
        output tm_dsc_sts_vld, tm_dsc_sts_qid, tm_dsc_sts_avl,
        output tm_dsc_sts_qen, tm_dsc_sts_dir, tm_dsc_sts_mm,
        output tm_dsc_sts_qinv, tm_dsc_sts_error,
        input  tm_dsc_sts_rdy,
        input  pkt_req_valid, pkt_req_qid,
        output pkt_req_ready
    );

endinterface

// File: rtl/c2h_credit_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Rotating priority encoder. Returns the first set bit of elig strictly
// after position ptr, wrapping cyclically (ptr itself is checked last).
//   elig  : per-queue eligibility vector
//   ptr   : index of the most recently granted queue
//   found : at least one eligible queue
//   idx   : chosen queue index (equals ptr when nothing is found)
// ---------------------------------------------------------------------------
module rr_pick
    import c2h_sched_pkg::*;
#(
    parameter int MAX_Q = DEF_MAX_Q,
    parameter int IDX_W = 4
) (
    input  logic [MAX_Q-1:0] elig,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Walk the distances from farthest to nearest so the nearest eligible
    // queue after the pointer is the last one written and therefore wins.
    always_comb begin
        int j;
        found = 1'b0;
        idx   = ptr;
        for (int k = MAX_Q; k >= 1; k--) begin
            j = int'(ptr) + k;
            if (j >= MAX_Q) begin
                j = j - MAX_Q;
            end
            if (elig[j[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/c2h_credit_sched.sv
// ---------------------------------------------------------------------------
// c2h_credit_sched
// Per-queue C2H descriptor-credit tracker and round-robin packet scheduler.
//   axi_aclk / axi_aresetn : clock, asynchronous active-low reset
//   enable                 : scheduling enable
//   qid_base / num_queue   : queue window (num_queue clamped to MAX_Q)
//   crd_per_pkt            : credits consumed per grant (0 acts as 1)
//   sched_if (slave)       : tm_dsc_sts_* status in, pkt_req_* grant out
//   crd_ovf                : sticky, a credit add saturated
//   grant_cnt              : completed grant handshakes
// ---------------------------------------------------------------------------
module c2h_credit_sched
    import c2h_sched_pkg::*;
#(
    parameter int MAX_Q = DEF_MAX_Q,
    parameter int CRD_W = DEF_CRD_W,
    parameter int QID_W = DEF_QID_W
) (
    input  logic                axi_aclk,
    input  logic                axi_aresetn,
    input  logic                enable,
    input  logic [QID_W-1:0]    qid_base,
    input  logic [QID_W-1:0]    num_queue,
    input  logic [CRD_W-1:0]    crd_per_pkt,
    c2h_credit_sched_if.slave   sched_if,
    output logic                crd_ovf,
    output logic [31:0]         grant_cnt
);

    localparam int IDX_W = (MAX_Q > 1) ? $clog2(MAX_Q) : 1;
    localparam logic [CRD_W-1:0] CRD_MAX = '1;

    sched_state_t     state;
    logic [CRD_W-1:0] credit     [MAX_Q];
    logic [CRD_W-1:0] credit_nxt [MAX_Q];
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [QID_W-1:0] eff_num;
    logic [CRD_W-1:0] eff_crd;
    logic [QID_W-1:0] sts_idx;
    logic             sts_hit;
    logic             grant_hs;
    logic             ovf_hit;
    logic [MAX_Q-1:0] elig;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    // Window size and per-grant cost after clamping. A status is used only
    // when it is a C2H streaming status for a queue inside the window; the
    // modular subtraction makes qids below qid_base land far out of range.
    always_comb begin
        eff_num  = (num_queue > QID_W'(MAX_Q)) ? QID_W'(MAX_Q) : num_queue;
        eff_crd  = (crd_per_pkt == '0) ? CRD_W'(1) : crd_per_pkt;
        sts_idx  = sched_if.tm_dsc_sts_qid - qid_base;
        sts_hit  = sched_if.tm_dsc_sts_vld & sched_if.tm_dsc_sts_rdy &
                   sched_if.tm_dsc_sts_qen & sched_if.tm_dsc_sts_dir &
                   ~sched_if.tm_dsc_sts_mm & ~sched_if.tm_dsc_sts_error &
                   (sts_idx < eff_num);
        grant_hs = (state == OFFER) & sched_if.pkt_req_ready;
    end

    // Next credit per queue. The status update is applied first, then the
    // grant charge on top of it, so a same-cycle add and grant on one queue
    // nets out correctly. A queue invalidation overrides everything.
    always_comb begin
        logic [CRD_W-1:0] upd;
        logic [32:0]      sat_res;
        logic             zeroed;
        ovf_hit = 1'b0;
        for (int i = 0; i < MAX_Q; i++) begin
            upd     = credit[i];
            sat_res = '0;
            zeroed  = 1'b0;
            if (sts_hit && (sts_idx == QID_W'(i))) begin
                if (sched_if.tm_dsc_sts_qinv) begin
                    upd    = '0;
                    zeroed = 1'b1;
                end else begin
                    sat_res = crd_sat_add(32'(credit[i]),
                                          32'(sched_if.tm_dsc_sts_avl),
                                          32'(CRD_MAX));
                    upd = sat_res[CRD_W-1:0];
                    if (sat_res[32]) begin
                        ovf_hit = 1'b1;
                    end
                end
            end
            if (grant_hs && (grant_idx == IDX_W'(i)) && !zeroed) begin
                upd = (upd >= eff_crd) ? (upd - eff_crd) : '0;
            end
            credit_nxt[i] = upd;
        end
    end

    // Credit table and sticky overflow flag.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < MAX_Q; i++) begin
                credit[i] <= '0;
            end
            crd_ovf <= 1'b0;
        end else begin
            credit  <= credit_nxt;
            crd_ovf <= crd_ovf | ovf_hit;
        end
    end

    // Status ready comes up one edge after reset release and then stays up.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            sched_if.tm_dsc_sts_rdy <= 1'b0;
        end else begin
            sched_if.tm_dsc_sts_rdy <= 1'b1;
        end
    end

    // A queue can be granted when it is inside the window and holds at
    // least one packet's worth of credit.
    always_comb begin
        for (int i = 0; i < MAX_Q; i++) begin
            elig[i] = (QID_W'(i) < eff_num) && (credit[i] >= eff_crd);
        end
    end

    rr_pick #(
        .MAX_Q (MAX_Q),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .elig  (elig),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant FSM. IDLE registers the picked queue and raises valid; OFFER
    // holds valid/qid untouched until the handshake, regardless of enable,
    // then moves the round-robin pointer to the granted queue.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state                  <= IDLE;
            sched_if.pkt_req_valid <= 1'b0;
            sched_if.pkt_req_qid   <= '0;
            grant_idx              <= '0;
            rr_ptr                 <= IDX_W'(MAX_Q - 1);
            grant_cnt              <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && pick_found) begin
                        grant_idx              <= pick_idx;
                        sched_if.pkt_req_qid   <= qid_base + QID_W'(pick_idx);
                        sched_if.pkt_req_valid <= 1'b1;
                        state                  <= OFFER;
                    end
                end
                OFFER: begin
                    if (sched_if.pkt_req_ready) begin
                        sched_if.pkt_req_valid <= 1'b0;
                        rr_ptr                 <= grant_idx;
                        grant_cnt              <= grant_cnt + 32'd1;
                        state                  <= IDLE;
                    end
                end
                default: begin
                    state                  <= IDLE;
                    sched_if.pkt_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c2h_credit_sched.sv
// ---------------------------------------------------------------------------
// tb_c2h_credit_sched
// Self-checking bench for c2h_credit_sched: directed scenarios followed by
// randomized traffic, checked against a queue-level reference model through
// an expected-grant scoreboard.
// ---------------------------------------------------------------------------
module tb_c2h_credit_sched;
    import c2h_sched_pkg::*;

    localparam int MAX_Q = 16;
    localparam int CRD_W = 16;
    localparam int QID_W = 11;
    localparam int CRD_LIMIT = 65535;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable;
    logic [QID_W-1:0]  qid_base;
    logic [QID_W-1:0]  num_queue;
    logic [CRD_W-1:0]  crd_per_pkt;
    logic              crd_ovf;
    logic [31:0]       grant_cnt;

    int total = 0;
    int bad   = 0;

    c2h_credit_sched_if #(.QID_W(QID_W)) sif ();

    c2h_credit_sched #(
        .MAX_Q (MAX_Q),
        .CRD_W (CRD_W),
        .QID_W (QID_W)
    ) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .enable      (enable),
        .qid_base    (qid_base),
        .num_queue   (num_queue),
        .crd_per_pkt (crd_per_pkt),
        .sched_if    (sif),
        .crd_ovf     (crd_ovf),
        .grant_cnt   (grant_cnt)
    );

    always #5 clk = ~clk;

    // One comparison: count it, and report it when it does not hold.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one descriptor status for a single cycle.
    task automatic applyStimulus(input int qid, input int avl, input bit qinv = 1'b0,
                                 input bit mm = 1'b0, input bit qen = 1'b1,
                                 input bit dir = 1'b1, input bit err = 1'b0);
        sif.tm_dsc_sts_qid   = QID_W'(qid);
        sif.tm_dsc_sts_avl   = 16'(avl);
        sif.tm_dsc_sts_qinv  = qinv;
        sif.tm_dsc_sts_mm    = mm;
        sif.tm_dsc_sts_qen   = qen;
        sif.tm_dsc_sts_dir   = dir;
        sif.tm_dsc_sts_error = err;
        sif.tm_dsc_sts_vld   = 1'b1;
        tick(1);
        sif.tm_dsc_sts_vld   = 1'b0;
    endtask

    task automatic waitValid(input int max_cycles, input string name);
        int n = 0;
        while (!sif.pkt_req_valid && n < max_cycles) begin
            tick(1);
            n++;
        end
        checkOutput({name, "_valid_timeout"}, 32'(sif.pkt_req_valid), 32'd1);
    endtask

    // -----------------------------------------------------------------------
    // Reference model: credits as plain integers, a pointer to the last
    // granted queue, and an "offer outstanding" flag. Each new offer pushes
    // the queue id it must carry into exp_q.
    // -----------------------------------------------------------------------
    int          m_crd [MAX_Q];
    bit          m_rdy, m_off, m_ovf;
    int          m_idx, m_ptr;
    int unsigned m_cnt;
    int          exp_q [$];

    task automatic modelStep();
        int old [MAX_Q];
        int win, cost, d, s, j;
        bit hs, acc, zeroed;
        old    = m_crd;
        win    = (int'(num_queue) > MAX_Q) ? MAX_Q : int'(num_queue);
        cost   = (crd_per_pkt == 0) ? 1 : int'(crd_per_pkt);
        hs     = m_off && sif.pkt_req_ready;
        d      = int'(sif.tm_dsc_sts_qid) - int'(qid_base);
        acc    = sif.tm_dsc_sts_vld && m_rdy && sif.tm_dsc_sts_qen && sif.tm_dsc_sts_dir &&
                 !sif.tm_dsc_sts_mm && !sif.tm_dsc_sts_error && d >= 0 && d < win;
        zeroed = 1'b0;
        if (acc) begin
            if (sif.tm_dsc_sts_qinv) begin
                m_crd[d] = 0;
                zeroed   = 1'b1;
            end else begin
                s = m_crd[d] + int'(sif.tm_dsc_sts_avl);
                if (s > CRD_LIMIT) begin
                    s     = CRD_LIMIT;
                    m_ovf = 1'b1;
                end
                m_crd[d] = s;
            end
        end
        if (hs && !(zeroed && d == m_idx)) begin
            m_crd[m_idx] = (m_crd[m_idx] > cost) ? m_crd[m_idx] - cost : 0;
        end
        if (hs) begin
            m_off = 1'b0;
            m_ptr = m_idx;
            m_cnt++;
        end else if (!m_off && enable) begin
            for (int k = 1; k <= MAX_Q; k++) begin
                j = (m_ptr + k) % MAX_Q;
                if (j < win && old[j] >= cost) begin
                    m_idx = j;
                    m_off = 1'b1;
                    exp_q.push_back((int'(qid_base) + j) % (1 << QID_W));
                    break;
                end
            end
        end
        m_rdy = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_Q; i++) m_crd[i] = 0;
            m_rdy = 1'b0;
            m_off = 1'b0;
            m_ovf = 1'b0;
            m_idx = 0;
            m_ptr = MAX_Q - 1;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            modelStep();
        end
    end

    // Monitor: every falling edge compares the visible outputs with the
    // model, pops the scoreboard on each new offer and checks that an
    // outstanding offer keeps its qid.
    logic             prev_valid = 1'b0;
    logic [QID_W-1:0] held_qid   = '0;

    always @(negedge clk) begin
        int e;
        checkOutput("pkt_req_valid", 32'(sif.pkt_req_valid), 32'(m_off));
        checkOutput("tm_dsc_sts_rdy", 32'(sif.tm_dsc_sts_rdy), 32'(m_rdy));
        checkOutput("grant_cnt", grant_cnt, m_cnt);
        checkOutput("crd_ovf", 32'(crd_ovf), 32'(m_ovf));
        if (sif.pkt_req_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL grant_qid: got 0x%0h with no grant expected", sif.pkt_req_qid);
            end else begin
                e = exp_q.pop_front();
                checkOutput("grant_qid", 32'(sif.pkt_req_qid), 32'(e));
            end
            held_qid = sif.pkt_req_qid;
        end else if (sif.pkt_req_valid && prev_valid) begin
            checkOutput("grant_qid_stable", 32'(sif.pkt_req_qid), 32'(held_qid));
        end
        prev_valid = sif.pkt_req_valid;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        enable               = 1'b0;
        qid_base             = '0;
        num_queue            = '0;
        crd_per_pkt          = 16'd1;
        sif.tm_dsc_sts_vld   = 1'b0;
        sif.tm_dsc_sts_qid   = '0;
        sif.tm_dsc_sts_avl   = '0;
        sif.tm_dsc_sts_qen   = 1'b1;
        sif.tm_dsc_sts_dir   = 1'b1;
        sif.tm_dsc_sts_mm    = 1'b0;
        sif.tm_dsc_sts_qinv  = 1'b0;
        sif.tm_dsc_sts_error = 1'b0;
        sif.pkt_req_ready    = 1'b0;

        // Reset held for 5 cycles, then ready one edge after release.
        tick(5);
        checkOutput("reset_valid", 32'(sif.pkt_req_valid), 32'd0);
        checkOutput("reset_qid", 32'(sif.pkt_req_qid), 32'd0);
        checkOutput("reset_rdy", 32'(sif.tm_dsc_sts_rdy), 32'd0);
        checkOutput("reset_ovf", 32'(crd_ovf), 32'd0);
        checkOutput("reset_cnt", grant_cnt, 32'd0);
        rst_n = 1'b1;
        tick(1);
        checkOutput("rdy_after_release", 32'(sif.tm_dsc_sts_rdy), 32'd1);

        // Single queue: only qid 2 is credited; out-of-window and mm statuses
        // are dropped.
        qid_base          = 11'd0;
        num_queue         = 11'd4;
        crd_per_pkt       = 16'd1;
        sif.pkt_req_ready = 1'b1;
        enable            = 1'b1;
        applyStimulus(5, 10);
        applyStimulus(1, 10, 1'b0, 1'b1);
        applyStimulus(2, 3);
        tick(20);
        checkOutput("single_q_cnt", grant_cnt, 32'd3);
        checkOutput("single_q_idle", 32'(sif.pkt_req_valid), 32'd0);

        // Backpressure with enable dropped while the offer is pending.
        sif.pkt_req_ready = 1'b0;
        applyStimulus(1, 2);
        waitValid(10, "bp");
        checkOutput("bp_qid", 32'(sif.pkt_req_qid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            if (c == 5) enable = 1'b0;
            tick(1);
            checkOutput("bp_hold_valid", 32'(sif.pkt_req_valid), 32'd1);
            checkOutput("bp_hold_qid", 32'(sif.pkt_req_qid), 32'd1);
        end
        sif.pkt_req_ready = 1'b1;
        tick(6);
        checkOutput("bp_cnt", grant_cnt, 32'd4);
        checkOutput("bp_no_more", 32'(sif.pkt_req_valid), 32'd0);
        applyStimulus(1, 0, 1'b1);

        // Saturation: 0xFFF0 + 0x20 must clip to 0xFFFF, which is exactly one
        // packet when crd_per_pkt is 0xFFFF.
        crd_per_pkt = 16'hFFFF;
        enable      = 1'b1;
        applyStimulus(3, 16'hFFF0);
        applyStimulus(3, 16'h0020);
        checkOutput("sat_ovf", 32'(crd_ovf), 32'd1);
        waitValid(5, "sat");
        checkOutput("sat_qid", 32'(sif.pkt_req_qid), 32'd3);
        tick(6);
        checkOutput("sat_cnt", grant_cnt, 32'd5);

        // Invalidation makes a credited queue ineligible.
        enable      = 1'b0;
        crd_per_pkt = 16'd1;
        applyStimulus(3, 16'h0040);
        applyStimulus(3, 0, 1'b1);
        enable = 1'b1;
        tick(10);
        checkOutput("qinv_cnt", grant_cnt, 32'd5);
        checkOutput("qinv_idle", 32'(sif.pkt_req_valid), 32'd0);

        // Collision: handshake on queue 0 in the same cycle as avl=5 -> 5 left.
        enable            = 1'b0;
        sif.pkt_req_ready = 1'b0;
        applyStimulus(0, 1);
        enable = 1'b1;
        waitValid(5, "col");
        checkOutput("col_qid", 32'(sif.pkt_req_qid), 32'd0);
        sif.pkt_req_ready = 1'b1;
        applyStimulus(0, 5);
        tick(20);
        checkOutput("col_cnt", grant_cnt, 32'd11);

        // Reset asserted while an offer is outstanding.
        sif.pkt_req_ready = 1'b0;
        applyStimulus(0, 1);
        waitValid(5, "rst");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", 32'(sif.pkt_req_valid), 32'd0);
        checkOutput("rst_mid_cnt", grant_cnt, 32'd0);
        checkOutput("rst_mid_ovf", 32'(crd_ovf), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        checkOutput("rdy_after_rst2", 32'(sif.tm_dsc_sts_rdy), 32'd1);

        // Round robin across 4 queues with 2048 credits each.
        qid_base          = 11'd0;
        num_queue         = 11'd4;
        crd_per_pkt       = 16'd1;
        sif.pkt_req_ready = 1'b1;
        enable            = 1'b1;
        for (int q = 0; q < 4; q++) applyStimulus(q, 2048);
        n = 0;
        while (grant_cnt < 32'd8192 && n < 20000) begin
            tick(1);
            n++;
        end
        tick(20);
        checkOutput("rr_cnt", grant_cnt, 32'd8192);
        checkOutput("rr_idle", 32'(sif.pkt_req_valid), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) qid_base = QID_W'($urandom_range(0, 200));
            if (c % 50 == 0) begin
                num_queue   = QID_W'($urandom_range(0, 20));
                crd_per_pkt = CRD_W'($urandom_range(0, 3));
            end
            enable            = ($urandom_range(0, 7) != 0);
            sif.pkt_req_ready = ($urandom_range(0, 2) != 0);
            sif.tm_dsc_sts_vld   = $urandom_range(0, 1);
            sif.tm_dsc_sts_qid   = qid_base + QID_W'($urandom_range(0, 20)) - QID_W'($urandom_range(0, 1));
            sif.tm_dsc_sts_avl   = ($urandom_range(0, 31) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
            sif.tm_dsc_sts_qinv  = ($urandom_range(0, 15) == 0);
            sif.tm_dsc_sts_mm    = ($urandom_range(0, 7) == 0);
            sif.tm_dsc_sts_qen   = ($urandom_range(0, 7) != 0);
            sif.tm_dsc_sts_dir   = ($urandom_range(0, 7) != 0);
            sif.tm_dsc_sts_error = ($urandom_range(0, 7) == 0);
            tick(1);
        end
        sif.tm_dsc_sts_vld = 1'b0;
        enable             = 1'b0;
        sif.pkt_req_ready  = 1'b1;
        tick(10);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
